// File: rtl/prio_pkg.sv
// prio_pkg -- shared definitions for the priority grant queue.
//   PRIO_N_REQ : default number of request channels.
//   MAX_REQ    : widest request vector the helper functions handle (N_REQ <= MAX_REQ).
//   idx_width / cnt_width : derive gnt_idx and pend_cnt widths from N_REQ.
//   onehot(idx)   : MAX_REQ-wide one-hot decode; callers keep the low N_REQ bits.
//   popcount(vec) : number of set bits in a MAX_REQ-wide vector.
package prio_pkg;

  localparam int PRIO_N_REQ = 16;
  localparam int MAX_REQ    = 64;
  localparam int MAX_IDX_W  = 6;
  localparam int MAX_CNT_W  = 7;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
    logic [MAX_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [MAX_CNT_W-1:0] popcount(input logic [MAX_REQ-1:0] vec);
    logic [MAX_CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      c = c + MAX_CNT_W'(vec[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// prio_pick -- combinational selector over a request vector.
//   vec       in  N_REQ  candidate bits
//   start_ptr in  IDX_W  round-robin pointer; search begins at start_ptr-1
//   rr_en     in  1      0 = highest set index wins, 1 = round-robin search
//   found     out 1      any bit of vec set
//   idx       out IDX_W  selected index (0 when !found)
module prio_pick
  import prio_pkg::*;
#(
  parameter int N_REQ = PRIO_N_REQ,
  parameter int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] vec,
  input  logic [IDX_W-1:0] start_ptr,
  input  logic             rr_en,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // A descending search from start_ptr-1 with wrap visits [start_ptr-1 .. 0]
  // first, then [N_REQ-1 .. start_ptr]. So: highest set bit below start_ptr
  // if there is one, otherwise highest set bit overall. With start_ptr == 0
  // the lower region is empty and this degenerates to fixed priority.
  logic             lo_found;
  logic [IDX_W-1:0] lo_idx;

  always_comb begin
    found    = 1'b0;
    idx      = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (vec[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
        if (rr_en && (i < int'(start_ptr))) begin
          lo_found = 1'b1;
          lo_idx   = IDX_W'(i);
        end
      end
    end
    if (lo_found) begin
      idx = lo_idx;
    end
  end

endmodule

// File: rtl/prio_grant_queue.sv
// prio_grant_queue -- registered priority grant queue.
// Request pulses latch into a sticky pending vector; one channel index at a
// time is presented over a valid/ready handshake. Highest index wins, or a
// round-robin search when built with PRIO_RR_EN and rr_mode=1.
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   req_in     in   N_REQ  request pulses, bit i sets pending[i]
//   rr_mode    in   1      round-robin select (only with PRIO_RR_EN)
//   gnt_ready  in   1      consumer accepts current grant
//   gnt_valid  out  1      grant register holds a valid index
//   gnt_idx    out  IDX_W  granted channel index
//   gnt_onehot out  N_REQ  one-hot of gnt_idx, 0 when !gnt_valid
//   gnt_none   out  1      no grant and nothing pending
//   pend_cnt   out  CNT_W  popcount of the pending vector
// Build option: define PRIO_RR_EN to add the round-robin pointer.
module prio_grant_queue
  import prio_pkg::*;
#(
  parameter int N_REQ = PRIO_N_REQ,
  localparam int IDX_W = idx_width(N_REQ),
  localparam int CNT_W = cnt_width(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_in,
  input  logic             rr_mode,
  input  logic             gnt_ready,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N_REQ-1:0] gnt_onehot,
  output logic             gnt_none,
  output logic [CNT_W-1:0] pend_cnt
);

  logic [N_REQ-1:0] pending_q, pending_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;

  logic             load;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] start_ptr;
  logic             rr_en;
  logic [MAX_REQ-1:0]   pick_oh_full;
  logic [MAX_REQ-1:0]   gnt_oh_full;
  logic [MAX_CNT_W-1:0] cnt_full;

  prio_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .vec       (pending_q),
    .start_ptr (start_ptr),
    .rr_en     (rr_en),
    .found     (pick_found),
    .idx       (pick_idx)
  );

`ifdef PRIO_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  assign rr_en     = rr_mode;
  assign start_ptr = ptr_q;

  // The pointer follows every real grant, in either mode, so switching to
  // round-robin continues from the most recent grant.
  always_comb begin
    ptr_d = ptr_q;
    if (load && pick_found) begin
      ptr_d = pick_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  logic unused_rr_mode;

  assign unused_rr_mode = rr_mode;
  assign rr_en          = 1'b0;
  assign start_ptr      = '0;
`endif

  // The grant register may take a new value when empty or being consumed.
  assign load         = !gnt_valid_q || gnt_ready;
  assign pick_oh_full = onehot(MAX_IDX_W'(pick_idx));

  always_comb begin
    gnt_valid_d = gnt_valid_q;
    gnt_idx_d   = gnt_idx_q;
    pending_d   = pending_q;
    if (load) begin
      gnt_valid_d = pick_found;
    end
    // gnt_idx keeps its last value when a load finds nothing to grant.
    if (load && pick_found) begin
      gnt_idx_d = pick_idx;
      pending_d = pending_q & ~pick_oh_full[N_REQ-1:0];
    end
    // OR-ing requests last makes a same-cycle re-request win over the clear.
    pending_d = pending_d | req_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= '0;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
    end else begin
      pending_q   <= pending_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_idx_q   <= gnt_idx_d;
    end
  end

  assign gnt_oh_full = onehot(MAX_IDX_W'(gnt_idx_q));
  assign cnt_full    = popcount(MAX_REQ'(pending_q));

  assign gnt_valid  = gnt_valid_q;
  assign gnt_idx    = gnt_idx_q;
  assign gnt_onehot = gnt_valid_q ? gnt_oh_full[N_REQ-1:0] : '0;
  assign gnt_none   = !gnt_valid_q && (pending_q == '0);
  assign pend_cnt   = cnt_full[CNT_W-1:0];

endmodule

// File: tb/tb_prio_grant_queue.sv
// tb_prio_grant_queue -- directed bench for prio_grant_queue (N_REQ=16).
// Expected grant indices are queued as stimulus is issued; a negedge monitor
// pops and compares on every accepted grant. Status outputs are checked
// directly by the stimulus thread at fixed points.
module tb_prio_grant_queue;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;
  localparam int CNT_W = 5;

  logic             clk;
  logic             rst_n;
  logic [N_REQ-1:0] req_in;
  logic             rr_mode;
  logic             gnt_ready;
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic [N_REQ-1:0] gnt_onehot;
  logic             gnt_none;
  logic [CNT_W-1:0] pend_cnt;

  int total = 0;
  int bad   = 0;

  logic [IDX_W-1:0] sb[$];
  logic [IDX_W-1:0] mon_exp;
  logic [N_REQ-1:0] mon_exp_oh;

  prio_grant_queue #(.N_REQ(N_REQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_in     (req_in),
    .rr_mode    (rr_mode),
    .gnt_ready  (gnt_ready),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot),
    .gnt_none   (gnt_none),
    .pend_cnt   (pend_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  // Grant monitor: a transfer happens at the next rising edge when
  // gnt_valid && gnt_ready, so sample on the falling edge before it.
  always @(negedge clk) begin
    if (rst_n && gnt_valid && gnt_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL grant_unexpected: got idx %0d expected none", gnt_idx);
      end else begin
        mon_exp = sb.pop_front();
        mon_exp_oh = '0;
        mon_exp_oh[mon_exp] = 1'b1;
        if (gnt_idx !== mon_exp || gnt_onehot !== mon_exp_oh) begin
          bad++;
          $display("FAIL grant: got idx %0d oh %h expected idx %0d oh %h",
                   gnt_idx, gnt_onehot, mon_exp, mon_exp_oh);
        end else begin
          $display("grant idx %0d oh %h ok", gnt_idx, gnt_onehot);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("check %s = %0h ok", name, act);
    end
  endtask

  task automatic drain(input string name, input int max_cyc);
    int n;
    n = 0;
    while (!(gnt_none && sb.size() == 0) && n < max_cyc) begin
      cyc();
      n++;
    end
    total++;
    if (n >= max_cyc) begin
      bad++;
      $display("FAIL %s_drain: got timeout after %0d cycles expected idle, %0d grants outstanding",
               name, n, sb.size());
    end else begin
      $display("drain %s idle after %0d cycles", name, n);
    end
  endtask

  task automatic push_desc(input int hi, input int lo);
    for (int i = hi; i >= lo; i--) sb.push_back(IDX_W'(i));
  endtask

  initial begin
    int hold;

    // 1. reset held with every request asserted
    rst_n     = 1'b0;
    req_in    = 16'hFFFF;
    rr_mode   = 1'b0;
    gnt_ready = 1'b1;
    repeat (3) cyc();
    chk("rst_valid",  32'(gnt_valid),  32'd0);
    chk("rst_idx",    32'(gnt_idx),    32'd0);
    chk("rst_onehot", 32'(gnt_onehot), 32'd0);
    chk("rst_none",   32'(gnt_none),   32'd1);
    chk("rst_cnt",    32'(pend_cnt),   32'd0);
    req_in = '0;
    rst_n  = 1'b1;
    cyc();
    chk("rel_none", 32'(gnt_none), 32'd1);
    chk("rel_cnt",  32'(pend_cnt), 32'd0);

    // 2. two simultaneous requests drain highest first
    sb.push_back(4'd15);
    sb.push_back(4'd0);
    req_in = 16'h8001;
    cyc();
    req_in = '0;
    chk("t2_cnt_latched", 32'(pend_cnt), 32'd2);
    cyc();
    chk("t2_idx_a", 32'(gnt_idx),  32'd15);
    chk("t2_cnt_a", 32'(pend_cnt), 32'd1);
    cyc();
    chk("t2_idx_b", 32'(gnt_idx),  32'd0);
    chk("t2_cnt_b", 32'(pend_cnt), 32'd0);
    cyc();
    chk("t2_valid_end", 32'(gnt_valid), 32'd0);
    chk("t2_none_end",  32'(gnt_none),  32'd1);
    chk("t2_idx_hold",  32'(gnt_idx),   32'd0);

    // 3. stall holds grant 3; later, higher request 12 does not pre-empt
    sb.push_back(4'd3);
    sb.push_back(4'd12);
    gnt_ready = 1'b0;
    req_in = 16'h0008;
    cyc();
    req_in = '0;
    cyc();
    req_in = 16'h1000;
    cyc();
    req_in = '0;
    for (int k = 0; k < 3; k++) begin
      chk("t3_stall_idx", 32'(gnt_idx),    32'd3);
      chk("t3_stall_oh",  32'(gnt_onehot), 32'h0008);
      chk("t3_stall_cnt", 32'(pend_cnt),   32'd1);
      cyc();
    end
    gnt_ready = 1'b1;
    cyc();
    chk("t3_after_idx", 32'(gnt_idx), 32'd12);
    drain("t3", 20);

    // 4a. all requests held, fixed priority
    rr_mode = 1'b0;
    for (int k = 0; k < 6; k++) sb.push_back(4'd15);
    push_desc(14, 0);
    req_in = 16'hFFFF;
    repeat (4) cyc();
    chk("t4_cnt_full", 32'(pend_cnt), 32'd16);
    repeat (2) cyc();
    req_in = '0;
    drain("t4_fixed", 40);

    // 4b. same pattern with rr_mode=1 (fixed behaviour without PRIO_RR_EN)
    rr_mode = 1'b1;
`ifdef PRIO_RR_EN
    hold = 18;
    push_desc(15, 0);
    sb.push_back(4'd15);
    push_desc(14, 0);
    sb.push_back(4'd15);
`else
    hold = 3;
    for (int k = 0; k < 3; k++) sb.push_back(4'd15);
    push_desc(14, 0);
`endif
    req_in = 16'hFFFF;
    repeat (hold) cyc();
    req_in = '0;
    drain("t4_rr", 60);
    rr_mode = 1'b0;

    // 5. re-request of the bit being loaded keeps it pending
    sb.push_back(4'd4);
    sb.push_back(4'd4);
    req_in = 16'h0010;
    cyc();
    cyc();
    req_in = '0;
    chk("t5_idx", 32'(gnt_idx),  32'd4);
    chk("t5_cnt", 32'(pend_cnt), 32'd1);
    cyc();
    chk("t5_idx_again", 32'(gnt_idx),  32'd4);
    chk("t5_cnt_after", 32'(pend_cnt), 32'd0);
    drain("t5", 10);

    // 6. asynchronous reset during a stall discards everything
    gnt_ready = 1'b0;
    req_in = 16'h00F0;
    cyc();
    req_in = '0;
    cyc();
    chk("t6_pre_valid", 32'(gnt_valid), 32'd1);
    chk("t6_pre_idx",   32'(gnt_idx),   32'd7);
    chk("t6_pre_cnt",   32'(pend_cnt),  32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid",  32'(gnt_valid),  32'd0);
    chk("t6_rst_idx",    32'(gnt_idx),    32'd0);
    chk("t6_rst_onehot", 32'(gnt_onehot), 32'd0);
    chk("t6_rst_none",   32'(gnt_none),   32'd1);
    chk("t6_rst_cnt",    32'(pend_cnt),   32'd0);
    repeat (2) cyc();
    rst_n = 1'b1;
    gnt_ready = 1'b1;
    repeat (4) cyc();
    chk("t6_post_valid", 32'(gnt_valid), 32'd0);
    chk("t6_post_none",  32'(gnt_none),  32'd1);
    sb.push_back(4'd2);
    req_in = 16'h0004;
    cyc();
    req_in = '0;
    cyc();
    chk("t6_new_idx", 32'(gnt_idx), 32'd2);
    drain("t6", 10);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
